conv_stream_driver: RTL and testbench
=====================================

// Module: conv_stream_driver
// PURPOSE
//  RTL front-end for the 12x12 convolution accelerator. It drives the accelerator's input
//  side (input_port, bias, valid, reset) and collects its result side (output_port, finish,
//  invalid). Per job it accepts one IMG_DIM*IMG_DIM pixel frame from an upstream ready/valid
//  stream, feeds it to the accelerator and returns one result beat with a status flag.
// PARAMETERS
//  DATA_W   8    pixel width (accelerator input_port width)
//  BIAS_W   8    bias width
//  OUT_W    20   accelerator output_port width
//  IMG_DIM  12   frame side; N = IMG_DIM*IMG_DIM pixels per job (144)
//  RST_CYC  2    cycles acc_reset is held high at job start (>=1)
//  TIMEOUT  256  max cycles in WAIT for finish/invalid (>=2)
// PORTS
//  h_clk          in   1       clock; all logic on posedge
//  reset_n        in   1       asynchronous, active-low reset
//  start          in   1       begin job; sampled in IDLE only
//  cfg_bias       in   BIAS_W  bias; latched on accepted start
//  s_valid        in   1       upstream pixel valid
//  s_ready        out  1       upstream pixel ready
//  s_data         in   DATA_W  upstream pixel
//  s_last         in   1       marks the last pixel of the frame
//  acc_input_port out  DATA_W  pixel to accelerator (registered)
//  acc_bias       out  BIAS_W  bias to accelerator (registered)
//  acc_valid      out  1       pixel valid to accelerator (registered)
//  acc_reset      out  1       active-high accelerator reset (registered)
//  acc_output_port in  OUT_W   accelerator result
//  acc_finish     in   1       accelerator done; result valid this cycle
//  acc_invalid    in   1       accelerator error indication
//  res_valid      out  1       one-cycle result pulse
//  res_data       out  OUT_W   captured result; holds until next res_valid
//  res_invalid    out  1       status for res_valid: 1 = invalid/abort/timeout
//  busy           out  1       high in every state except IDLE
//  err_len        out  1       sticky frame-length error; cleared on accepted start
// BEHAVIOUR
//  Reset (reset_n=0, async): state=IDLE; acc_reset=1; all other outputs and counters 0.
//   acc_reset drops to 0 on the first clock edge after reset release.
//  FSM: IDLE -> ACC_RST -> STREAM -> WAIT -> IDLE.
//  IDLE: s_ready=0. On start=1: latch cfg_bias into acc_bias, clear err_len, go to ACC_RST.
//  ACC_RST: acc_reset=1 for exactly RST_CYC cycles, then 0. Then go to STREAM.
//  STREAM: s_ready=1. Each accepted beat (s_valid&s_ready) gives acc_input_port<=s_data and
//   acc_valid<=1 next cycle; acc_valid=0 after a cycle with no accept. pix_cnt counts 0..N-1.
//   - Accept with pix_cnt==N-1: go to WAIT. If s_last=0 on that beat, set err_len.
//   - Accept with s_last=1 and pix_cnt<N-1: set err_len, pulse res_valid with res_invalid=1,
//     drive acc_reset=1 for 1 cycle, go to IDLE. No further pixels are forwarded.
//   - acc_invalid=1 in STREAM: pulse res_valid with res_invalid=1 and res_data=0, go to IDLE.
//     The beat in that cycle is not accepted (s_ready is 0 combinationally).
//  WAIT: s_ready=0, acc_valid=0, wait counter starts at 0.
//   - On acc_finish or acc_invalid: next cycle res_valid=1, res_data=acc_output_port
//     (sampled), res_invalid=acc_invalid (invalid wins if both). Go to IDLE.
//   - Counter reaches TIMEOUT-1 with neither: res_valid=1, res_invalid=1, res_data=0,
//     acc_reset=1 for 1 cycle. Go to IDLE.
//  acc_bias is stable from ACC_RST through WAIT. start is ignored while busy.
//  acc_finish or acc_invalid seen in IDLE or ACC_RST is ignored.
//  Reset mid-job: immediate return to the reset values; the partial frame is discarded.
//  Latency: s_data to acc_input_port is 1 cycle; acc_finish to res_valid is 1 cycle.
//  Counters are sized $clog2(N) and $clog2(TIMEOUT). No wrap occurs; the FSM exits first.
// TESTING (IMG_DIM=12, RST_CYC=2, TIMEOUT=256)
//  1 Reset: reset_n=0 mid-STREAM -> acc_reset=1, busy=0, s_ready=0 at once. After release,
//    acc_reset=0 one cycle later. All other outputs are 0.
//  2 Normal: start with cfg_bias=8'h05, then 144 pixels 0..143 back-to-back (s_last on #143).
//    Expect acc_reset high 2 cycles, 144 acc_valid beats mirroring the data 1 cycle later,
//    and acc_bias=5 throughout. acc_finish with output 20'h1234 -> res_valid 1 cycle,
//    res_data=20'h1234, res_invalid=0, err_len=0.
//  3 Backpressure gaps: s_valid toggles randomly -> acc_valid has exactly 144 beats in
//    order, with no duplicates.
//  4 Early s_last on pixel #99 -> err_len=1, res_valid with res_invalid=1, acc_reset pulse,
//    busy=0. Pixels after #99 are not forwarded.
//  5 No finish: 144 pixels, then silence -> res_valid with res_invalid=1 exactly 256 cycles
//    after WAIT entry, plus an acc_reset pulse.
//  6 acc_invalid at pixel #50 -> abort with res_invalid=1. A start issued while busy is
//    ignored, and a fresh start after the abort runs scenario 2 correctly.

Source files
------------

// File: rtl/conv_stream_driver.sv
// Stream front-end for the 12x12 convolution accelerator: resets the accelerator, forwards
// one pixel frame from a ready/valid stream, then waits for and returns one result beat.
module conv_stream_driver #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned BIAS_W  = 8,
  parameter int unsigned OUT_W   = 20,
  parameter int unsigned IMG_DIM = 12,
  parameter int unsigned RST_CYC = 2,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic              h_clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [BIAS_W-1:0] cfg_bias,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic [DATA_W-1:0] acc_input_port,
  output logic [BIAS_W-1:0] acc_bias,
  output logic              acc_valid,
  output logic              acc_reset,
  input  logic [OUT_W-1:0]  acc_output_port,
  input  logic              acc_finish,
  input  logic              acc_invalid,
  output logic              res_valid,
  output logic [OUT_W-1:0]  res_data,
  output logic              res_invalid,
  output logic              busy,
  output logic              err_len
);

  localparam int unsigned N     = IMG_DIM * IMG_DIM;
  localparam int unsigned PixW  = $clog2(N);
  localparam int unsigned WaitW = $clog2(TIMEOUT);
  // A single reset cycle still needs a 1-bit counter.
  localparam int unsigned RstW  = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  localparam logic [PixW-1:0]  PixLast  = PixW'(N - 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);
  localparam logic [RstW-1:0]  RstLast  = RstW'(RST_CYC - 1);

  typedef enum logic [1:0] {StIdle, StAccRst, StStream, StWait} state_e;

  state_e              state_q, state_d;
  logic [PixW-1:0]     pix_cnt_q, pix_cnt_d;
  logic [WaitW-1:0]    wait_cnt_q, wait_cnt_d;
  logic [RstW-1:0]     rst_cnt_q, rst_cnt_d;
  logic                acc_reset_q, acc_reset_d;
  logic                acc_valid_q, acc_valid_d;
  logic [DATA_W-1:0]   acc_input_q, acc_input_d;
  logic [BIAS_W-1:0]   acc_bias_q, acc_bias_d;
  logic                res_valid_q, res_valid_d;
  logic [OUT_W-1:0]    res_data_q, res_data_d;
  logic                res_invalid_q, res_invalid_d;
  logic                err_len_q, err_len_d;

  // Next-state, handshake and registered-output decode.
  always_comb begin
    state_d       = state_q;
    pix_cnt_d     = pix_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    rst_cnt_d     = rst_cnt_q;
    acc_reset_d   = 1'b0;
    acc_valid_d   = 1'b0;
    acc_input_d   = acc_input_q;
    acc_bias_d    = acc_bias_q;
    res_valid_d   = 1'b0;
    res_data_d    = res_data_q;
    res_invalid_d = res_invalid_q;
    err_len_d     = err_len_q;
    s_ready       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          acc_bias_d  = cfg_bias;
          err_len_d   = 1'b0;
          acc_reset_d = 1'b1;
          rst_cnt_d   = '0;
          state_d     = StAccRst;
        end
      end
      StAccRst: begin
        if (rst_cnt_q == RstLast) begin
          pix_cnt_d = '0;
          state_d   = StStream;
        end else begin
          acc_reset_d = 1'b1;
          rst_cnt_d   = rst_cnt_q + RstW'(1);
        end
      end
      StStream: begin
        // An accelerator error blocks the beat presented in the same cycle.
        s_ready = ~acc_invalid;
        if (acc_invalid) begin
          res_valid_d   = 1'b1;
          res_invalid_d = 1'b1;
          res_data_d    = '0;
          state_d       = StIdle;
        end else if (s_valid) begin
          acc_valid_d = 1'b1;
          acc_input_d = s_data;
          if (pix_cnt_q == PixLast) begin
            wait_cnt_d = '0;
            state_d    = StWait;
            if (!s_last) err_len_d = 1'b1;
          end else if (s_last) begin
            // Short frame: abort and reset the accelerator's partial state.
            err_len_d     = 1'b1;
            res_valid_d   = 1'b1;
            res_invalid_d = 1'b1;
            res_data_d    = '0;
            acc_reset_d   = 1'b1;
            state_d       = StIdle;
          end else begin
            pix_cnt_d = pix_cnt_q + PixW'(1);
          end
        end
      end
      StWait: begin
        if (acc_finish || acc_invalid) begin
          res_valid_d   = 1'b1;
          res_data_d    = acc_output_port;
          res_invalid_d = acc_invalid;
          state_d       = StIdle;
        end else if (wait_cnt_q == WaitLast) begin
          res_valid_d   = 1'b1;
          res_invalid_d = 1'b1;
          res_data_d    = '0;
          acc_reset_d   = 1'b1;
          state_d       = StIdle;
        end else begin
          wait_cnt_d = wait_cnt_q + WaitW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; acc_reset comes out of reset asserted.
  always_ff @(posedge h_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      pix_cnt_q     <= '0;
      wait_cnt_q    <= '0;
      rst_cnt_q     <= '0;
      acc_reset_q   <= 1'b1;
      acc_valid_q   <= 1'b0;
      acc_input_q   <= '0;
      acc_bias_q    <= '0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      res_invalid_q <= 1'b0;
      err_len_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pix_cnt_q     <= pix_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      rst_cnt_q     <= rst_cnt_d;
      acc_reset_q   <= acc_reset_d;
      acc_valid_q   <= acc_valid_d;
      acc_input_q   <= acc_input_d;
      acc_bias_q    <= acc_bias_d;
      res_valid_q   <= res_valid_d;
      res_data_q    <= res_data_d;
      res_invalid_q <= res_invalid_d;
      err_len_q     <= err_len_d;
    end
  end

  assign acc_input_port = acc_input_q;
  assign acc_bias       = acc_bias_q;
  assign acc_valid      = acc_valid_q;
  assign acc_reset      = acc_reset_q;
  assign res_valid      = res_valid_q;
  assign res_data       = res_data_q;
  assign res_invalid    = res_invalid_q;
  assign err_len        = err_len_q;
  assign busy           = (state_q != StIdle);

endmodule

// File: tb/tb_conv_stream_driver.sv
// Directed bench for conv_stream_driver: normal frame, gaps, short frame, timeout,
// accelerator abort and asynchronous reset mid-job.
module tb_conv_stream_driver;

  logic        h_clk;
  logic        reset_n;
  logic        start;
  logic [7:0]  cfg_bias;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        s_last;
  logic [7:0]  acc_input_port;
  logic [7:0]  acc_bias;
  logic        acc_valid;
  logic        acc_reset;
  logic [19:0] acc_output_port;
  logic        acc_finish;
  logic        acc_invalid;
  logic        res_valid;
  logic [19:0] res_data;
  logic        res_invalid;
  logic        busy;
  logic        err_len;

  int checks   = 0;
  int failures = 0;

  logic [7:0] beats[$];
  int         rst_hi   = 0;
  int         res_cnt  = 0;
  int         bias_bad = 0;
  logic [7:0] exp_bias = 8'h00;

  conv_stream_driver #(
    .DATA_W (8),
    .BIAS_W (8),
    .OUT_W  (20),
    .IMG_DIM(12),
    .RST_CYC(2),
    .TIMEOUT(256)
  ) dut (
    .h_clk          (h_clk),
    .reset_n        (reset_n),
    .start          (start),
    .cfg_bias       (cfg_bias),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_data         (s_data),
    .s_last         (s_last),
    .acc_input_port (acc_input_port),
    .acc_bias       (acc_bias),
    .acc_valid      (acc_valid),
    .acc_reset      (acc_reset),
    .acc_output_port(acc_output_port),
    .acc_finish     (acc_finish),
    .acc_invalid    (acc_invalid),
    .res_valid      (res_valid),
    .res_data       (res_data),
    .res_invalid    (res_invalid),
    .busy           (busy),
    .err_len        (err_len)
  );

  initial h_clk = 1'b0;
  always #5 h_clk = ~h_clk;

  // Observe the accelerator side on the falling edge, clear of the active edge.
  always @(negedge h_clk) begin
    if (acc_valid) beats.push_back(acc_input_port);
    if (acc_reset) rst_hi++;
    if (res_valid) res_cnt++;
    if (busy && acc_bias !== exp_bias) bias_bad++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge h_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    beats.delete();
    rst_hi   = 0;
    res_cnt  = 0;
    bias_bad = 0;
  endtask

  task automatic do_start(input logic [7:0] bias);
    start    = 1'b1;
    cfg_bias = bias;
    exp_bias = bias;
    tick();
    start    = 1'b0;
    cfg_bias = 8'hee;
    chk("start_busy", busy, 1);
    chk("start_acc_reset", acc_reset, 1);
    chk("start_bias", acc_bias, bias);
  endtask

  // Offer pixels 0..n-1; last_idx marks s_last (-1 = never). Returns after the final accept.
  task automatic send(input int n, input int last_idx, input bit gaps);
    int   i   = 0;
    int   cyc = 0;
    logic hs;
    while (i < n && cyc < 3000) begin
      s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data  = 8'(i);
      s_last  = (i == last_idx);
      #1;
      hs = s_valid && s_ready;
      tick();
      cyc++;
      if (hs) i++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk("send_done", i, n);
  endtask

  task automatic check_order(input string tag, input int n);
    int bad = 0;
    for (int k = 0; k < beats.size(); k++) if (beats[k] !== 8'(k)) bad++;
    chk({tag, "_count"}, beats.size(), n);
    chk({tag, "_order"}, bad, 0);
  endtask

  task automatic run_normal(input logic [7:0] bias, input logic [19:0] out, input bit gaps);
    clear_mon();
    do_start(bias);
    send(144, 143, gaps);
    tick();
    chk("wait_s_ready", s_ready, 0);
    chk("wait_busy", busy, 1);
    check_order("frame", 144);
    chk("acc_rst_cycles", rst_hi, 2);
    acc_output_port = out;
    acc_finish      = 1'b1;
    tick();
    acc_finish      = 1'b0;
    acc_output_port = 20'h0beef;
    chk("res_valid", res_valid, 1);
    chk("res_data", res_data, out);
    chk("res_invalid", res_invalid, 0);
    chk("err_len_ok", err_len, 0);
    chk("idle_busy", busy, 0);
    tick();
    chk("res_pulse_end", res_valid, 0);
    chk("res_data_hold", res_data, out);
    chk("res_pulses", res_cnt, 1);
    chk("bias_stable", bias_bad, 0);
  endtask

  initial begin
    reset_n         = 1'b0;
    start           = 1'b0;
    cfg_bias        = 8'h00;
    s_valid         = 1'b0;
    s_data          = 8'h00;
    s_last          = 1'b0;
    acc_output_port = 20'h0;
    acc_finish      = 1'b0;
    acc_invalid     = 1'b0;
    tick();
    tick();
    chk("rst_acc_reset", acc_reset, 1);
    chk("rst_busy", busy, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_err_len", err_len, 0);
    #2 reset_n = 1'b1;
    tick();
    chk("rel_acc_reset", acc_reset, 0);

    // Completion indications while idle are ignored.
    acc_finish  = 1'b1;
    acc_invalid = 1'b1;
    tick();
    acc_finish  = 1'b0;
    acc_invalid = 1'b0;
    tick();
    chk("idle_ignore", res_valid, 0);
    chk("idle_ignore_cnt", res_cnt, 0);

    // Normal job, then one with random source gaps.
    run_normal(8'h05, 20'h01234, 1'b0);
    run_normal(8'h9a, 20'habcde, 1'b1);

    // Accelerator error mid-stream, plus a start while busy.
    clear_mon();
    do_start(8'h3c);
    start    = 1'b1;
    cfg_bias = 8'h77;
    tick();
    start    = 1'b0;
    chk("busy_start_bias", acc_bias, 8'h3c);
    send(50, -1, 1'b0);
    s_valid     = 1'b1;
    s_data      = 8'd50;
    acc_invalid = 1'b1;
    #1;
    chk("inv_s_ready", s_ready, 0);
    tick();
    acc_invalid = 1'b0;
    s_valid     = 1'b0;
    chk("inv_res_valid", res_valid, 1);
    chk("inv_res_invalid", res_invalid, 1);
    chk("inv_res_data", res_data, 0);
    chk("inv_busy", busy, 0);
    tick();
    check_order("inv", 50);
    chk("inv_rst_cycles", rst_hi, 2);
    chk("inv_bias", bias_bad, 0);
    run_normal(8'h05, 20'h01234, 1'b0);

    // Early s_last on pixel #99.
    clear_mon();
    do_start(8'h21);
    send(100, 99, 1'b0);
    chk("short_err_len", err_len, 1);
    chk("short_res_valid", res_valid, 1);
    chk("short_res_invalid", res_invalid, 1);
    chk("short_acc_reset", acc_reset, 1);
    chk("short_busy", busy, 0);
    s_valid = 1'b1;
    s_data  = 8'd200;
    for (int k = 0; k < 5; k++) tick();
    s_valid = 1'b0;
    check_order("short", 100);
    chk("short_rst_cycles", rst_hi, 3);
    chk("short_err_sticky", err_len, 1);

    // No finish: timeout 256 cycles after entering WAIT.
    begin
      int k = 0;
      clear_mon();
      do_start(8'h11);
      chk("start_clears_err", err_len, 0);
      send(144, 143, 1'b0);
      while (k < 400 && !res_valid) begin
        tick();
        k++;
      end
      chk("to_cycles", k, 256);
      chk("to_res_invalid", res_invalid, 1);
      chk("to_res_data", res_data, 0);
      chk("to_acc_reset", acc_reset, 1);
      chk("to_busy", busy, 0);
      chk("to_err_len", err_len, 0);
      tick();
      chk("to_acc_reset_end", acc_reset, 0);
      chk("to_res_end", res_valid, 0);
      chk("to_rst_cycles", rst_hi, 3);
    end

    // Asynchronous reset in the middle of a stream.
    clear_mon();
    do_start(8'h42);
    send(10, -1, 1'b0);
    s_valid = 1'b1;
    s_data  = 8'h55;
    #3 reset_n = 1'b0;
    #1;
    chk("mid_rst_acc_reset", acc_reset, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_s_ready", s_ready, 0);
    chk("mid_rst_acc_valid", acc_valid, 0);
    chk("mid_rst_bias", acc_bias, 0);
    chk("mid_rst_pixel", acc_input_port, 0);
    chk("mid_rst_res_data", res_data, 0);
    s_valid = 1'b0;
    tick();
    #2 reset_n = 1'b1;
    #1;
    chk("mid_rel_hold", acc_reset, 1);
    tick();
    chk("mid_rel_acc_reset", acc_reset, 0);
    chk("mid_rel_busy", busy, 0);
    exp_bias = 8'h00;
    run_normal(8'h05, 20'h01234, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
